// File: rtl/calc_accumulator_pkg.sv
// Shared calculator definitions: opcode encodings, FSM state encodings and
// the datapath widths used by the accumulator and its bench.
package calc_accumulator_pkg;

   localparam int DATA_W = 16;
   localparam int RES_W  = DATA_W + 1;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_ADD   = 2'b01,
      OP_SUB   = 2'b10,
      OP_CLEAR = 2'b11
   } calc_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } calc_state_t;

   // SUB runs through the adder as acc + ~operand + 1.
   function automatic logic is_sub(input calc_op_t op);
      return op == OP_SUB;
   endfunction

endpackage

// File: rtl/calc_accumulator_if.sv
// Request / result bus of the accumulator.
//   in_valid/in_ready/in_op/in_data : request channel (master -> slave)
//   res_valid/res_ready/res_data    : result channel (slave -> master)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the sender holds its payload stable while valid=1 and ready=0.
interface calc_accumulator_if;
   import calc_accumulator_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_op;
   logic [DATA_W-1:0] in_data;
   logic              res_valid;
   logic              res_ready;
   logic [RES_W-1:0]  res_data;

   modport master (
      output in_valid, in_op, in_data, res_ready,
      input  in_ready, res_valid, res_data
   );

   modport slave (
      input  in_valid, in_op, in_data, res_ready,
      output in_ready, res_valid, res_data
   );

endinterface

// File: rtl/calc_accumulator_adder.sv
// 16-bit adder with carry-in and a 17-bit sum (bit 16 is carry-out).
//   a, b : operands
//   cin  : carry-in
//   sum  : {carry_out, sum[15:0]}
module math_adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [16:0] sum
);

   assign sum = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule

// File: rtl/calc_accumulator.sv
// Accumulator with a LOAD/ADD/SUB/CLEAR request channel and a result channel.
// One request at a time: IDLE accepts, EXEC computes for one cycle, DONE
// presents the result until it is taken.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus       : request/result interface (slave side)
//   acc       : registered accumulator value
//   dbg_state : current FSM state
module calc_accumulator
   import calc_accumulator_pkg::*;
#(
   parameter bit SAT_EN = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   calc_accumulator_if.slave   bus,
   output logic [DATA_W-1:0]   acc,
   output calc_state_t         dbg_state
);

   calc_state_t       state, state_nxt;
   calc_op_t          op_q;
   logic [DATA_W-1:0] data_q;
   logic [RES_W-1:0]  res_q;

   logic [DATA_W-1:0] add_b;
   logic              add_cin;
   logic [RES_W-1:0]  sum;
   logic [DATA_W-1:0] new_acc;
   logic              new_flag;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nxt = EXEC;
         EXEC:                       state_nxt = DONE;
         DONE:    if (bus.res_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.res_valid = (state == DONE);
   assign bus.res_data  = res_q;
   assign dbg_state     = state;

   // ---------------- request capture ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= OP_LOAD;
         data_q <= '0;
      end else if (state == IDLE && bus.in_valid) begin
         op_q   <= calc_op_t'(bus.in_op);
         data_q <= bus.in_data;
      end
   end

   // ---------------- datapath ----------------
   assign add_b   = is_sub(op_q) ? ~data_q : data_q;
   assign add_cin = is_sub(op_q);

   math_adder_16bit u_adder (
      .a   (acc),
      .b   (add_b),
      .cin (add_cin),
      .sum (sum)
   );

   always_comb begin
      new_acc  = sum[DATA_W-1:0];
      new_flag = 1'b0;
      case (op_q)
         OP_LOAD: begin
            new_acc  = data_q;
            new_flag = 1'b0;
         end
         OP_ADD: begin
            new_flag = sum[DATA_W];
            if (SAT_EN && sum[DATA_W]) new_acc = '1;
         end
         OP_SUB: begin
            // carry-out of acc + ~b + 1 is set when no borrow occurred
            new_flag = ~sum[DATA_W];
            if (SAT_EN && !sum[DATA_W]) new_acc = '0;
         end
         OP_CLEAR: begin
            new_acc  = '0;
            new_flag = 1'b0;
         end
         default: begin
            new_acc  = acc;
            new_flag = 1'b0;
         end
      endcase
   end

   // acc and the result register only move at the end of EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         res_q <= '0;
      end else if (state == EXEC) begin
         acc   <= new_acc;
         res_q <= {new_flag, new_acc};
      end
   end

endmodule

// File: tb/tb_calc_accumulator.sv
// Bench for calc_accumulator: two instances (wrapping and saturating) share
// one request stream; a negedge monitor pops expected results on handshake.
module tb_calc_accumulator;
   import calc_accumulator_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   calc_accumulator_if bus0 ();
   calc_accumulator_if bus1 ();

   logic [15:0] acc0, acc1;
   calc_state_t st0, st1;

   assign bus1.in_valid  = bus0.in_valid;
   assign bus1.in_op     = bus0.in_op;
   assign bus1.in_data   = bus0.in_data;
   assign bus1.res_ready = bus0.res_ready;

   calc_accumulator #(.SAT_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .acc(acc0), .dbg_state(st0)
   );

   calc_accumulator #(.SAT_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .acc(acc1), .dbg_state(st1)
   );

   // ---------------- scoreboard ----------------
   int checks       = 0;
   int failures     = 0;
   int results_seen = 0;
   int n_expected   = 0;

   logic [16:0] exp_q0[$];
   logic [16:0] exp_q1[$];
   logic [15:0] m_acc0, m_acc1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] d,
                                         input logic [15:0] a, input bit sat);
      logic [16:0] s;
      s = '0;
      case (op)
         2'b00: model = {1'b0, d};
         2'b01: begin
            s = {1'b0, a} + {1'b0, d};
            model = (sat && s[16]) ? 17'h1FFFF : s;
         end
         2'b10: begin
            if (d > a) model = sat ? 17'h10000 : {1'b1, a - d};
            else       model = {1'b0, a - d};
         end
         default: model = 17'h00000;
      endcase
   endfunction

   task automatic push(input logic [1:0] op, input logic [15:0] d);
      logic [16:0] r0, r1;
      r0 = model(op, d, m_acc0, 1'b0);
      r1 = model(op, d, m_acc1, 1'b1);
      exp_q0.push_back(r0);
      exp_q1.push_back(r1);
      m_acc0 = r0[15:0];
      m_acc1 = r1[15:0];
      n_expected++;
   endtask

   task automatic flush_model();
      n_expected -= exp_q0.size();
      exp_q0.delete();
      exp_q1.delete();
      m_acc0 = '0;
      m_acc1 = '0;
   endtask

   always @(negedge clk) begin
      if (!rst && bus0.res_valid && bus0.res_ready) begin
         results_seen++;
         chk("result_expected", 32'(exp_q0.size() != 0), 32'd1);
         chk("res_valid_sat", 32'(bus1.res_valid), 32'd1);
         if (exp_q0.size() != 0) begin
            chk("res_data_wrap", 32'(bus0.res_data), 32'(exp_q0[0]));
            chk("acc_wrap", 32'(acc0), 32'(exp_q0[0][15:0]));
            chk("res_data_sat", 32'(bus1.res_data), 32'(exp_q1[0]));
            chk("acc_sat", 32'(acc1), 32'(exp_q1[0][15:0]));
            void'(exp_q0.pop_front());
            void'(exp_q1.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic accept(input logic [1:0] op, input logic [15:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus0.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 32'(bus0.in_ready), 32'd1);
      bus0.in_valid = 1'b1;
      bus0.in_op    = op;
      bus0.in_data  = d;
      @(posedge clk);
      push(op, d);
      #1 bus0.in_valid = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] d);
      accept(op, d);
      chk("exec_no_valid", 32'(bus0.res_valid), 32'd0);
      chk("exec_not_ready", 32'(bus0.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("done_valid_wrap", 32'(bus0.res_valid), 32'd1);
      chk("done_valid_sat", 32'(bus1.res_valid), 32'd1);
   endtask

   task automatic drain();
      bus0.res_ready = 1'b1;
      @(posedge clk);
      #1 bus0.res_ready = 1'b0;
      chk("idle_after_ack", 32'(bus0.in_ready), 32'd1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   logic [1:0]  bop [5];
   logic [15:0] bd  [5];

   initial begin
      int idx, cyc;
      logic [1:0]  rop;
      logic [15:0] rd;

      rst            = 1'b1;
      bus0.in_valid  = 1'b0;
      bus0.in_op     = 2'b00;
      bus0.in_data   = '0;
      bus0.res_ready = 1'b0;
      m_acc0         = '0;
      m_acc1         = '0;

      // reset state, before any clock edge
      #2;
      chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
      chk("rst_res_valid", 32'(bus0.res_valid), 32'd0);
      chk("rst_acc", 32'(acc0), 32'd0);
      chk("rst_res_data", 32'(bus0.res_data), 32'd0);
      chk("rst_state", 32'(st0), 32'(IDLE));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // LOAD 1, ADD 1
      issue(2'b00, 16'h0001); drain();
      issue(2'b01, 16'h0001); drain();

      // LOAD FFFF, ADD FFFF: wrap vs saturate
      issue(2'b00, 16'hFFFF); drain();
      issue(2'b01, 16'hFFFF); drain();

      // CLEAR, SUB 1 (borrow); LOAD 0FFF, SUB 0FFF (exact zero)
      issue(2'b11, 16'hABCD); drain();
      issue(2'b10, 16'h0001); drain();
      issue(2'b00, 16'h0FFF); drain();
      issue(2'b10, 16'h0FFF); drain();

      // res_ready while nothing is pending has no effect
      bus0.res_ready = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("idle_ready_no_valid", 32'(bus0.res_valid), 32'd0);
         chk("idle_ready_acc", 32'(acc0), 32'(m_acc0));
      end
      bus0.res_ready = 1'b0;

      // random operations
      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         rd  = 16'($urandom_range(0, 16'hFFFF));
         issue(rop, rd); drain();
      end

      // stall in DONE with stray requests
      issue(2'b00, 16'h8000); drain();
      issue(2'b01, 16'h0100);
      for (int k = 0; k < 3; k++) begin
         bus0.in_valid = 1'b1;
         bus0.in_op    = 2'b11;
         bus0.in_data  = 16'h1234;
         @(posedge clk); #1;
         bus0.in_valid = 1'b0;
         chk("stall_valid", 32'(bus0.res_valid), 32'd1);
         chk("stall_not_ready", 32'(bus0.in_ready), 32'd0);
         chk("stall_data_wrap", 32'(bus0.res_data), 32'(exp_q0[0]));
         chk("stall_data_sat", 32'(bus1.res_data), 32'(exp_q1[0]));
      end
      drain();
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_no_extra", 32'(bus0.res_valid), 32'd0);
      end

      // reset in EXEC
      accept(2'b00, 16'h1234);
      #3 rst = 1'b1;
      #1;
      chk("rst_exec_in_ready", 32'(bus0.in_ready), 32'd1);
      chk("rst_exec_res_valid", 32'(bus0.res_valid), 32'd0);
      chk("rst_exec_acc", 32'(acc0), 32'd0);
      chk("rst_exec_res_data", 32'(bus0.res_data), 32'd0);
      flush_model();
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_exec_no_result", 32'(bus0.res_valid), 32'd0);
         chk("rst_exec_acc_hold", 32'(acc1), 32'd0);
      end

      // reset in DONE
      accept(2'b00, 16'h5678);
      @(posedge clk); #1;
      chk("pre_rst_done_valid", 32'(bus0.res_valid), 32'd1);
      #3 rst = 1'b1;
      #1;
      chk("rst_done_in_ready", 32'(bus0.in_ready), 32'd1);
      chk("rst_done_res_valid", 32'(bus0.res_valid), 32'd0);
      chk("rst_done_acc", 32'(acc0), 32'd0);
      chk("rst_done_res_data", 32'(bus1.res_data), 32'd0);
      flush_model();
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_done_no_result", 32'(bus0.res_valid), 32'd0);
      end

      // first request after reset is accepted straight away
      issue(2'b01, 16'h0042); drain();

      // back-to-back with in_valid held high
      bop[0] = 2'b00; bd[0] = 16'hFFF0;
      bop[1] = 2'b01; bd[1] = 16'h0020;
      bop[2] = 2'b10; bd[2] = 16'h0030;
      bop[3] = 2'b01; bd[3] = 16'h7777;
      bop[4] = 2'b11; bd[4] = 16'h0000;
      bus0.res_ready = 1'b1;
      idx = 0;
      cyc = 0;
      bus0.in_valid = 1'b1;
      bus0.in_op    = bop[0];
      bus0.in_data  = bd[0];
      while (idx < 5 && cyc < 100) begin
         @(negedge clk);
         if (bus0.in_ready) begin
            @(posedge clk);
            push(bop[idx], bd[idx]);
            idx++;
            #1;
            if (idx < 5) begin
               bus0.in_op   = bop[idx];
               bus0.in_data = bd[idx];
            end else begin
               bus0.in_valid = 1'b0;
            end
         end
         cyc++;
      end
      bus0.in_valid = 1'b0;
      chk("b2b_all_accepted", 32'(idx), 32'd5);
      cyc = 0;
      while (exp_q0.size() != 0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      @(posedge clk); #1 bus0.res_ready = 1'b0;

      // final bookkeeping
      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", 32'(exp_q0.size()), 32'd0);
      chk("result_count", 32'(results_seen), 32'(n_expected));
      chk("final_idle", 32'(st0), 32'(IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
